// File: rtl/clock_domain_exporter.sv
// Source side of a req/ack toggle CDC: holds a word on cd_e_data, toggles cd_e_req, waits for ack.
// Define CLOCK_DOMAIN_EXPORTER_SKID_EN to add a one-entry holding register accepted during WAIT.
module clock_domain_exporter #(
    parameter int unsigned pBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             cd_e_req,
    output logic [pBits-1:0] cd_e_data,
    input  logic             cd_i_ack,
    input  logic             stb,
    input  logic [pBits-1:0] data,
    output logic             ready,
    output logic             overrun
);

    typedef enum logic [1:0] {StResync, StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       ack_ff;
    logic             ack_sync;
    logic             req_q, req_d;
    logic [pBits-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;
`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
    logic             hold_v_q, hold_v_d;
    logic [pBits-1:0] hold_q, hold_d;
`endif

    assign ack_sync  = ack_ff[0];
    assign cd_e_req  = req_q;
    assign cd_e_data = data_q;
    assign overrun   = overrun_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        ready   = 1'b0;
`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
`endif
        unique case (state_q)
            StResync: begin
                // Adopt whatever parity the far end currently acknowledges.
                req_d = ack_sync;
                cnt_d = cnt_q + 2'd1;
`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
                hold_v_d = 1'b0;
`endif
                if (cnt_q == 2'd2) state_d = StIdle;
            end
            StIdle: begin
                ready = 1'b1;
                if (stb) begin
                    data_d  = data;
                    req_d   = ~req_q;
                    state_d = StWait;
                end
            end
            StWait: begin
`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
                ready = ~hold_v_q;
                if (ack_sync == req_q) begin
                    if (hold_v_q) begin
                        data_d   = hold_q;
                        req_d    = ~req_q;
                        hold_v_d = 1'b0;
                    end else if (stb) begin
                        data_d = data;
                        req_d  = ~req_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (stb && !hold_v_q) begin
                    hold_v_d = 1'b1;
                    hold_d   = data;
                end
`else
                if (ack_sync == req_q) state_d = StIdle;
`endif
            end
            default: state_d = StResync;
        endcase
        overrun_d = stb & ~ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StResync;
            cnt_q     <= 2'd0;
            ack_ff    <= 2'b00;
            req_q     <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
            hold_v_q  <= 1'b0;
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_ff    <= {cd_i_ack, ack_ff[1]};
            req_q     <= req_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
            hold_v_q  <= hold_v_d;
            hold_q    <= hold_d;
`endif
        end
    end

endmodule

// File: tb/tb_clock_domain_exporter.sv
// Bench for clock_domain_exporter: importer model on a separate far clock plus a
// word-count reference model of the exporter's visible behaviour.
module tb_clock_domain_exporter;

`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic       clk, far_clk, rst;
    logic       cd_e_req, cd_i_ack, stb, ready, overrun;
    logic [7:0] cd_e_data, data;
    int         far_half;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    bit chk_en = 0;

    // Importer model (far domain)
    logic       imp_ff1, imp_ack, imp_load, imp_val, ack_ovr;
    logic [7:0] rx_q[$];

    // Reference model state
    logic [7:0] acc_q[$];
    int         m_rs, m_done;
    bit         m_s1, m_s2, m_base;
    bit         exp_req, exp_ready, exp_ovr, exp_idle;
    logic [7:0] exp_data;

    assign cd_i_ack = ack_ovr ? 1'b1 : imp_ack;

    clock_domain_exporter #(.pBits(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cd_e_req  (cd_e_req),
        .cd_e_data (cd_e_data),
        .cd_i_ack  (cd_i_ack),
        .stb       (stb),
        .data      (data),
        .ready     (ready),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #15 clk = ~clk;
    end

    initial begin
        far_clk = 1'b0;
        forever #(far_half) far_clk = ~far_clk;
    end

    always @(posedge far_clk) begin
        if (imp_load) begin
            imp_ff1 <= imp_val;
            imp_ack <= imp_val;
        end else begin
            imp_ff1 <= cd_e_req;
            if (imp_ff1 != imp_ack) begin
                imp_ack <= imp_ff1;
                rx_q.push_back(cd_e_data);
            end
        end
    end

    // Model: words accepted vs. words acknowledged; a word is acknowledged once the
    // far ack, seen two local clocks late, matches the parity of words launched.
    always @(posedge clk) begin : model
        int n, launched;
        bit rdy, sync;
        if (!rst) begin
            m_rs = 0; m_s1 = 0; m_s2 = 0; m_base = 0; m_done = 0;
            acc_q.delete();
            exp_ovr = 0;
        end else begin
            n    = acc_q.size() - m_done;
            rdy  = (m_rs == 3) && (n < Cap);
            sync = m_s2;
            if (m_rs < 3) begin
                m_base = sync;
                m_rs++;
            end else if (n > 0 && sync == (m_base ^ (((m_done + 1) % 2) == 1))) begin
                m_done++;
            end
            if (stb && rdy) acc_q.push_back(data);
            exp_ovr = stb && !rdy;
            m_s2 = m_s1;
            m_s1 = cd_i_ack;
        end
        n         = acc_q.size() - m_done;
        launched  = m_done + ((n > 0) ? 1 : 0);
        exp_req   = m_base ^ ((launched % 2) == 1);
        exp_data  = (launched > 0) ? acc_q[launched-1] : 8'h00;
        exp_ready = (m_rs == 3) && (n < Cap);
        exp_idle  = (n == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (overrun === 1'b1) ovr_cnt++;
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("req", 32'(cd_e_req), 32'(exp_req));
            chk("data", 32'(cd_e_data), 32'(exp_data));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 400 && !exp_ready; i++) tick();
        chk("wait_ready", 32'(exp_ready), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && !exp_idle; i++) tick();
        for (int i = 0; i < 8; i++) tick();
        chk("wait_idle", 32'(exp_idle), 32'd1);
    endtask

    task automatic send(input logic [7:0] w);
        stb  = 1'b1;
        data = w;
        tick();
        stb  = 1'b0;
    endtask

    task automatic run_words(input int half);
        int rx0, ov0;
        far_half = half;
        wait_idle();
        rx0 = rx_q.size();
        ov0 = ovr_cnt;
        for (int i = 0; i < 16; i++) begin
            wait_ready();
            send(8'(i));
        end
        wait_idle();
        chk("words_count", 32'(rx_q.size() - rx0), 32'd16);
        for (int i = 0; i < 16 && rx0 + i < rx_q.size(); i++)
            chk("words_order", 32'(rx_q[rx0+i]), 32'(i));
        chk("words_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
    endtask

    initial begin
        int         rx0, a0;
        logic [7:0] w;
        bit         r0;
        far_half = 15;
        rst = 1'b0; stb = 1'b0; data = 8'h00;
        ack_ovr = 1'b0; imp_load = 1'b1; imp_val = 1'b0;

        // Reset with far ack = 0
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_req", 32'(cd_e_req), 32'd0);
        chk("rst_data", 32'(cd_e_data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk_en = 1;
        imp_load = 1'b0;
        rst = 1'b1;
        chk("resync_0", 32'(ready), 32'd0);
        tick(); chk("resync_1", 32'(ready), 32'd0);
        tick(); chk("resync_2", 32'(ready), 32'd0);
        tick(); chk("resync_done", 32'(ready), 32'd1);
        chk("resync_req", 32'(cd_e_req), 32'd0);

        // Single word, far clock equal to clk: minimum stb-to-ready of 5 clocks
        rx0 = rx_q.size();
        send(8'hA5);
        chk("a5_data", 32'(cd_e_data), 32'hA5);
        chk("a5_req", 32'(cd_e_req), 32'd1);
        chk("a5_busy", 32'(ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a5_wait", 32'(ready), 32'd0);
        end
        tick();
        chk("a5_ready5", 32'(ready), 32'd1);
        chk("a5_rx_count", 32'(rx_q.size() - rx0), 32'd1);
        if (rx_q.size() > rx0) chk("a5_rx_data", 32'(rx_q[rx0]), 32'hA5);

        // 16 words with a fast and a slow far clock
        run_words(5);
        run_words(41);

`ifdef CLOCK_DOMAIN_EXPORTER_SKID_EN
        // Skid: second word held, third dropped
        wait_idle();
        rx0 = rx_q.size();
        send(8'h11);
        send(8'h22);
        chk("skid_no_ovr", 32'(overrun), 32'd0);
        chk("skid_data_11", 32'(cd_e_data), 32'h11);
        send(8'h33);
        chk("skid_ovr", 32'(overrun), 32'd1);
        for (int i = 0; i < 200 && cd_e_data !== 8'h22; i++) tick();
        chk("skid_launch", 32'(cd_e_data), 32'h22);
        wait_idle();
        chk("skid_rx_count", 32'(rx_q.size() - rx0), 32'd2);
        if (rx_q.size() >= rx0 + 2) begin
            chk("skid_rx_0", 32'(rx_q[rx0]), 32'h11);
            chk("skid_rx_1", 32'(rx_q[rx0+1]), 32'h22);
        end
`else
        // Three strobes while waiting: three delayed overrun pulses, outputs held
        wait_idle();
        send(8'h3C);
        r0 = exp_req;
        for (int k = 0; k < 3; k++) begin
            stb  = 1'b1;
            data = 8'hC0 + 8'(k);
            tick();
            chk("drop_ovr", 32'(overrun), 32'd1);
            chk("drop_data", 32'(cd_e_data), 32'h3C);
            chk("drop_req", 32'(cd_e_req), 32'(r0));
        end
        stb = 1'b0;
        tick();
        chk("drop_ovr_end", 32'(overrun), 32'd0);
        wait_idle();
`endif

        // Randomized traffic against the model
        far_half = 7;
        wait_idle();
        rx0 = rx_q.size();
        a0  = acc_q.size();
        for (int i = 0; i < 300; i++) begin
            stb  = ($urandom_range(0, 2) == 0);
            data = 8'($urandom);
            tick();
        end
        stb = 1'b0;
        wait_idle();
        chk("rand_count", 32'(rx_q.size() - rx0), 32'(acc_q.size() - a0));
        for (int i = 0; i < acc_q.size() - a0 && rx0 + i < rx_q.size(); i++)
            chk("rand_order", 32'(rx_q[rx0+i]), 32'(acc_q[a0+i]));

        // Stale ack: far side holds ack=1 while only the exporter is reset
        ack_ovr = 1'b1; imp_val = 1'b1; imp_load = 1'b1;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("stale_req", 32'(cd_e_req), 32'd1);
        chk("stale_ready", 32'(ready), 32'd1);
        imp_load = 1'b0;
        ack_ovr  = 1'b0;
        tick();
        rx0 = rx_q.size();
        w = 8'h5A;
        send(w);
        chk("stale_req_toggle", 32'(cd_e_req), 32'd0);
        wait_idle();
        chk("stale_done_ready", 32'(ready), 32'd1);
        chk("stale_rx_count", 32'(rx_q.size() - rx0), 32'd1);
        if (rx_q.size() > rx0) chk("stale_rx_data", 32'(rx_q[rx0]), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
